// File: rtl/if_stage.sv
// if_stage: MIPS instruction-fetch stage; owns the PC, the imem request handshake and the IF/ID register.
// Build option: define IF_JUMP_EN to let i_jump/i_jump_index redirect fetch (otherwise only i_pc_src does).
`timescale 1ns/1ps
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_pc_src,
  input  logic [31:0] i_branch_addr,
  input  logic        i_jump,
  input  logic [25:0] i_jump_index,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_imem_ack,
  output logic [31:0] o_next_pc,
  output logic [31:0] o_data,
  output logic        o_valid
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DROP} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_target;
  logic [31:0] w_target_nxt;
  logic [31:0] r_buf;
  logic [31:0] w_buf_nxt;
  logic [31:0] r_next_pc;
  logic [31:0] w_next_pc_nxt;
  logic [31:0] r_data;
  logic [31:0] w_data_nxt;
  logic        r_valid;
  logic        w_valid_nxt;

  logic [31:0] w_pc_plus4;
  logic        w_redirect;
  logic [31:0] w_redirect_pc;

  assign w_pc_plus4 = r_pc + 32'd4;

`ifdef IF_JUMP_EN
  // The jump sits in ID, so its PC+4 is what IF/ID currently holds.
  logic [31:0] w_jump_pc;
  assign w_jump_pc     = {r_next_pc[31:28], i_jump_index, 2'b00};
  assign w_redirect    = i_pc_src | i_jump;
  assign w_redirect_pc = i_pc_src ? i_branch_addr : w_jump_pc;
`else
  logic w_unused_jump;
  assign w_unused_jump = ^{i_jump, i_jump_index};
  assign w_redirect    = i_pc_src;
  assign w_redirect_pc = i_branch_addr;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_target_nxt  = r_target;
    w_buf_nxt     = r_buf;
    w_next_pc_nxt = r_next_pc;
    w_data_nxt    = r_data;
    w_valid_nxt   = r_valid;

    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
        if (!i_stall) begin
          w_next_pc_nxt = 32'd0;
          w_data_nxt    = 32'd0;
          w_valid_nxt   = 1'b0;
        end
      end
      S_FETCH: begin
        if (i_imem_ack && !i_stall) begin
          w_next_pc_nxt = w_pc_plus4;
          w_data_nxt    = i_imem_rdata;
          w_valid_nxt   = 1'b1;
          w_pc_nxt      = w_pc_plus4;
        end else if (i_imem_ack) begin
          w_buf_nxt   = i_imem_rdata;
          w_state_nxt = S_HOLD;
        end else if (!i_stall) begin
          w_next_pc_nxt = 32'd0;
          w_data_nxt    = 32'd0;
          w_valid_nxt   = 1'b0;
        end
      end
      S_HOLD: begin
        if (!i_stall) begin
          w_next_pc_nxt = w_pc_plus4;
          w_data_nxt    = r_buf;
          w_valid_nxt   = 1'b1;
          w_pc_nxt      = w_pc_plus4;
          w_state_nxt   = S_FETCH;
        end
      end
      S_DROP: begin
        // r_pc still holds the abandoned address so the request stays stable until ack.
        if (i_imem_ack) begin
          w_pc_nxt    = r_target;
          w_state_nxt = S_FETCH;
        end
        if (!i_stall) begin
          w_next_pc_nxt = 32'd0;
          w_data_nxt    = 32'd0;
          w_valid_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Flush wins over stall; an unacked request must still be drained before the target goes out.
    if (w_redirect) begin
      w_next_pc_nxt = 32'd0;
      w_data_nxt    = 32'd0;
      w_valid_nxt   = 1'b0;
      w_buf_nxt     = 32'd0;
      if ((r_state == S_FETCH || r_state == S_DROP) && !i_imem_ack) begin
        w_state_nxt  = S_DROP;
        w_pc_nxt     = r_pc;
        w_target_nxt = w_redirect_pc;
      end else begin
        w_state_nxt  = S_FETCH;
        w_pc_nxt     = w_redirect_pc;
        w_target_nxt = w_redirect_pc;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_target  <= RESET_PC;
      r_buf     <= 32'd0;
      r_next_pc <= 32'd0;
      r_data    <= 32'd0;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_target  <= w_target_nxt;
      r_buf     <= w_buf_nxt;
      r_next_pc <= w_next_pc_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
    end
  end

  assign o_imem_req  = (r_state == S_FETCH) || (r_state == S_DROP);
  assign o_imem_addr = r_pc;
  assign o_next_pc   = r_next_pc;
  assign o_data      = r_data;
  assign o_valid     = r_valid;

endmodule
